// File: rtl/dm_dma.sv
// Block-transfer DMA master for the data memory: overlap-safe copy
// and constant fill over wrap-around addresses.
module dm_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic [DW-1:0] mem_dat_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_buf;
  logic [DW-1:0] r_fill;
  logic          r_bwd;

  logic [AW-1:0] w_diff;
  logic          w_bwd;
  logic [AW-1:0] w_src_end;
  logic [AW-1:0] w_dst_end;
  logic          w_last;

  // dst lands inside the source window: copy from the top down
  assign w_diff    = dst - src;
  assign w_bwd     = ~mode && (dst != src) && (w_diff < len);
  assign w_src_end = src + len - ONE;
  assign w_dst_end = dst + len - ONE;
  assign w_last    = (r_cnt == ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)  w_next = S_DONE;
          else if (mode)  w_next = S_FILL;
          else            w_next = S_RD;
        end
      end
      S_RD: begin
        busy     = 1'b1;
        mem_addr = r_src;
        w_next   = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        mem_addr   = r_dst;
        mem_dat_in = r_buf;
        mem_wr_en  = 1'b1;
        w_next     = w_last ? S_DONE : S_RD;
      end
      S_FILL: begin
        busy       = 1'b1;
        mem_addr   = r_dst;
        mem_dat_in = r_fill;
        mem_wr_en  = 1'b1;
        w_next     = w_last ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_buf  <= '0;
      r_fill <= '0;
      r_bwd  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= len;
            r_fill <= fill_val;
            r_bwd  <= w_bwd;
            r_src  <= w_bwd ? w_src_end : src;
            r_dst  <= w_bwd ? w_dst_end : dst;
          end
        end
        S_RD: r_buf <= mem_dat_out;
        S_WR: begin
          r_cnt <= r_cnt - ONE;
          r_src <= r_bwd ? r_src - ONE : r_src + ONE;
          r_dst <= r_bwd ? r_dst - ONE : r_dst + ONE;
        end
        S_FILL: begin
          r_cnt <= r_cnt - ONE;
          r_dst <= r_dst + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dma.sv
// Directed bench for dm_dma with a behavioural single-port memory.
// Each check is an immediate assertion against a hand-computed value.
module tb_dm_dma;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [7:0] len = '0;
  logic [7:0] fill_val = '0;
  logic [7:0] mem_dat_out;
  logic [7:0] mem_addr;
  logic [7:0] mem_dat_in;
  logic       mem_wr_en;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;

  int total = 0;
  int bad = 0;

  int dc, bn, wn, fa;

  always #5 clk = ~clk;

  assign mem_dat_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  dm_dma #(.AW(8), .DW(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .mode(mode),
    .src(src),
    .dst(dst),
    .len(len),
    .fill_val(fill_val),
    .mem_dat_out(mem_dat_out),
    .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in),
    .mem_wr_en(mem_wr_en),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] l,
                          input logic [7:0] f);
    @(negedge clk);
    mode     = m;
    src      = s;
    dst      = d;
    len      = l;
    fill_val = f;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles counted from the start edge; stops at done or budget.
  task automatic measure(output int dcyc, output int bcnt,
                         output int wcnt, output int faddr);
    int cyc;
    cyc   = 0;
    dcyc  = 0;
    bcnt  = 0;
    wcnt  = 0;
    faddr = -1;
    while (cyc < 600 && dcyc == 0) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (mem_wr_en) begin
        if (wcnt == 0) faddr = int'(mem_addr);
        wcnt++;
      end
      if (done) dcyc = cyc;
    end
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdat", mem_dat_in, 0);
    #14 reset_n = 1'b1;

    // forward copy
    poke(8'h10, 8'hA1);
    poke(8'h11, 8'hB2);
    poke(8'h12, 8'hC3);
    poke(8'h13, 8'hD4);
    do_start(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
    measure(dc, bn, wn, fa);
    chk("fwd_done_cyc", dc, 9);
    chk("fwd_busy_cyc", bn, 8);
    chk("fwd_writes", wn, 4);
    chk("fwd_first_wa", fa, 32'h40);
    @(negedge clk);
    chk("fwd_done_once", done, 0);
    chk("fwd_m40", mem[8'h40], 8'hA1);
    chk("fwd_m41", mem[8'h41], 8'hB2);
    chk("fwd_m42", mem[8'h42], 8'hC3);
    chk("fwd_m43", mem[8'h43], 8'hD4);
    chk("fwd_src13", mem[8'h13], 8'hD4);

    // overlapping backward copy
    poke(8'h20, 8'h01);
    poke(8'h21, 8'h02);
    poke(8'h22, 8'h03);
    poke(8'h23, 8'h04);
    do_start(1'b0, 8'h20, 8'h22, 8'd4, 8'h00);
    measure(dc, bn, wn, fa);
    chk("bwd_done_cyc", dc, 9);
    chk("bwd_first_wa", fa, 32'h25);
    chk("bwd_m22", mem[8'h22], 8'h01);
    chk("bwd_m23", mem[8'h23], 8'h02);
    chk("bwd_m24", mem[8'h24], 8'h03);
    chk("bwd_m25", mem[8'h25], 8'h04);

    // fill with wrap-around
    poke(8'h02, 8'h77);
    do_start(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A);
    measure(dc, bn, wn, fa);
    chk("fill_done_cyc", dc, 5);
    chk("fill_busy_cyc", bn, 4);
    chk("fill_mFE", mem[8'hFE], 8'h5A);
    chk("fill_mFF", mem[8'hFF], 8'h5A);
    chk("fill_m00", mem[8'h00], 8'h5A);
    chk("fill_m01", mem[8'h01], 8'h5A);
    chk("fill_m02", mem[8'h02], 8'h77);

    // len = 0
    do_start(1'b0, 8'h10, 8'h50, 8'd0, 8'h00);
    measure(dc, bn, wn, fa);
    chk("len0_done_cyc", dc, 1);
    chk("len0_writes", wn, 0);
    chk("len0_busy", bn, 0);

    // start while busy is ignored
    poke(8'h30, 8'h11);
    poke(8'h31, 8'h22);
    poke(8'h32, 8'h33);
    poke(8'h80, 8'hEE);
    do_start(1'b0, 8'h30, 8'h50, 8'd3, 8'h00);
    @(negedge clk);
    @(negedge clk);
    mode     = 1'b1;
    dst      = 8'h80;
    len      = 8'd1;
    fill_val = 8'h99;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    measure(dc, bn, wn, fa);
    chk("ign_done_cyc", dc, 5);
    chk("ign_m80", mem[8'h80], 8'hEE);
    chk("ign_m50", mem[8'h50], 8'h11);
    chk("ign_m52", mem[8'h52], 8'h33);
    repeat (3) @(negedge clk);
    chk("ign_no_queue", busy, 0);

    // async reset during a write
    poke(8'h60, 8'hC0);
    poke(8'h61, 8'hC1);
    do_start(1'b0, 8'h60, 8'h90, 8'd8, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("ar_in_wr", mem_wr_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_wr_low", mem_wr_en, 0);
    chk("ar_busy_low", busy, 0);
    chk("ar_done_low", done, 0);
    chk("ar_addr_zero", mem_addr, 0);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_idle", busy, 0);
    do_start(1'b1, 8'h00, 8'hA0, 8'd2, 8'h3C);
    measure(dc, bn, wn, fa);
    chk("ar_fill_done", dc, 3);
    chk("ar_fill_mA0", mem[8'hA0], 8'h3C);
    chk("ar_fill_mA1", mem[8'hA1], 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
